frigate_xo_startup_ctrl: RTL and testbench
==========================================

// Module: frigate_xo_startup_ctrl
// PURPOSE
//  Sequences one crystal oscillator (LSXO or HSXO) of the timing frontend: enable, bias settle,
//  release standby, qualify dout activity, then flag ready. Monitors for loss of clock while running.
//  Sits in the always-on digital domain; one instance per XO. A system clock mux consumes xo_ready/xo_fault.
// PARAMETERS
//  CNT_W         16     width of all internal cycle counters
//  STARTUP_CYC   16000  cycles with ena=1, standby=1 before standby release (1 ms @ 16 MHz)
//  STABLE_EDGES  64     synchronized rising edges of xo_dout required to qualify
//  TIMEOUT_CYC   65535  max cycles in WAIT_STABLE before fault
//  LOSS_CYC      2048   max cycles between edges in RUN before fault
//  RETRY_CYC     4096   FAULT dwell before auto-retry (FRIGATE_XO_AUTORETRY_EN only)
//  MAX_RETRY     3      auto-retry attempts per request (FRIGATE_XO_AUTORETRY_EN only)
// PORTS
//  clk           in   1      controller clock (RC 16 MHz)
//  reset         in   1      asynchronous reset, active-high
//  xo_req        in   1      level request to run the oscillator
//  xo_dout       in   1      raw oscillator output, asynchronous to clk
//  xo_ena        out  1      to oscillator ena
//  xo_standby    out  1      to oscillator standby
//  xo_ready      out  1      oscillator qualified and running
//  xo_fault      out  1      startup timeout or loss of clock
//  xo_state      out  3      FSM state, debug
// BEHAVIOUR
//  - Reset (async assert, sync deassert by parent): state=IDLE; xo_ena=0, xo_standby=0, xo_ready=0,
//    xo_fault=0, xo_state=0, all counters 0, retry count 0. Reset mid-sequence aborts immediately.
//  - xo_dout: 2-FF synchronizer plus a third flop; edge = sync & ~prev (2-3 cycle latency).
//    xo_dout frequency must be < clk/3; HSXO is pre-divided upstream.
//  - All outputs registered. Encoding: IDLE=0 BIAS=1 WAIT_STABLE=2 RUN=3 FAULT=4.
//  - IDLE: ena=0 standby=0. xo_req=1 -> BIAS, cycle counter cleared.
//  - BIAS: ena=1 standby=1; counts cycles; at count==STARTUP_CYC-1 -> WAIT_STABLE, counters cleared.
//  - WAIT_STABLE: ena=1 standby=0; counts cycles and edges. Edge count reaching STABLE_EDGES -> RUN
//    (xo_ready=1 next cycle). Cycle count reaching TIMEOUT_CYC without that -> FAULT.
//    Both on the same cycle: RUN wins.
//  - RUN: ena=1 standby=0 ready=1. Gap counter clears on each edge; reaching LOSS_CYC -> FAULT.
//    An edge on the limit cycle clears the counter; no fault.
//  - FAULT: ena=0 standby=0 ready=0 fault=1. Behaviour depends on FRIGATE_XO_AUTORETRY_EN.
//  - xo_req=0 in any state -> IDLE next cycle; ena/ready/fault clear and retry count resets.
//    This overrides every other transition on the same cycle, including fault detection.
//  - Counters saturate and never wrap; STARTUP_CYC, TIMEOUT_CYC, LOSS_CYC must be <= 2**CNT_W-1.
//  - Re-assertion of xo_req after IDLE always restarts from BIAS; no state is retained.
// CONFIGURATION
//  FRIGATE_XO_AUTORETRY_EN defined:
//    - FAULT dwells RETRY_CYC cycles, then -> BIAS if retries < MAX_RETRY; increments retry count.
//    - After MAX_RETRY failures, FAULT is sticky until xo_req=0.
//    - Retry count clears on entry to RUN.
//    - xo_fault is high throughout FAULT dwell and clears on re-entry to BIAS.
//  FRIGATE_XO_AUTORETRY_EN undefined:
//    - FAULT is sticky until xo_req=0; RETRY_CYC and MAX_RETRY are unused.
// TESTING  (bench params: STARTUP_CYC=8 STABLE_EDGES=4 TIMEOUT_CYC=100 LOSS_CYC=20 RETRY_CYC=10 MAX_RETRY=2)
//  1. Reset high, req=1, dout toggling -> all outputs 0, state=0 while reset held.
//  2. req=1, dout period 6 clk -> ena=1/standby=1 for 8 cycles, then standby=0; ready=1 after 4th synced edge.
//  3. req=1, dout stuck 0 -> fault=1 and ena=0 exactly 100 cycles after standby release; ready never 1.
//  4. In RUN, stop dout -> ready=0, fault=1 within 20 cycles + sync latency of last edge;
//     dout edge every 19 cycles -> no fault.
//  5. Autoretry on, dout stuck -> BIAS re-entered twice, 10 cycles after each fault; third fault sticky.
//     Autoretry off -> fault sticky after first.
//  6. req drop mid-BIAS, mid-WAIT_STABLE, and on the same cycle as a fault -> IDLE next cycle;
//     ena=0, fault=0; req=1 again -> full 8-cycle BIAS.

Source files
------------

// File: rtl/frigate_xo_startup_ctrl.sv
// frigate_xo_startup_ctrl: crystal oscillator enable / bias / qualify / run sequencer.
// Define FRIGATE_XO_AUTORETRY_EN to let FAULT retry from BIAS up to MAX_RETRY times.
module frigate_xo_startup_ctrl #(
   parameter int CNT_W        = 16,
   parameter int STARTUP_CYC  = 16000,
   parameter int STABLE_EDGES = 64,
   parameter int TIMEOUT_CYC  = 65535,
   parameter int LOSS_CYC     = 2048,
   parameter int RETRY_CYC    = 4096,
   parameter int MAX_RETRY    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       xo_req,
   input  logic       xo_dout,
   output logic       xo_ena,
   output logic       xo_standby,
   output logic       xo_ready,
   output logic       xo_fault,
   output logic [2:0] xo_state
);

   localparam int RW =
      (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0] BIAS_LIM =
      CNT_W'(STARTUP_CYC - 1);
   localparam logic [CNT_W-1:0] EDGE_LIM =
      CNT_W'(STABLE_EDGES - 1);
   localparam logic [CNT_W-1:0] TMO_LIM =
      CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] LOSS_LIM =
      CNT_W'(LOSS_CYC - 1);
   localparam logic [CNT_W-1:0] RTRY_LIM =
      CNT_W'(RETRY_CYC - 1);
   localparam logic [RW-1:0] RETRY_MAX =
      RW'(MAX_RETRY);

`ifdef FRIGATE_XO_AUTORETRY_EN
   localparam logic AUTORETRY = 1'b1;
`else
   localparam logic AUTORETRY = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BIAS  = 3'd1,
      S_WAIT  = 3'd2,
      S_RUN   = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cyc_q;
   logic [CNT_W-1:0] cyc_d;
   logic [CNT_W-1:0] edg_q;
   logic [CNT_W-1:0] edg_d;
   logic [RW-1:0]    retry_q;
   logic [RW-1:0]    retry_d;

   logic ena_q;
   logic ena_d;
   logic stby_q;
   logic stby_d;
   logic rdy_q;
   logic rdy_d;
   logic flt_q;
   logic flt_d;

   logic sync1_q;
   logic sync2_q;
   logic sync3_q;
   logic dout_edge;

   // Counters stop at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Bring xo_dout into clk domain; third flop gives the previous value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= xo_dout;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign dout_edge = sync2_q & ~sync3_q;

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         edg_q   <= '0;
         retry_q <= '0;
         ena_q   <= 1'b0;
         stby_q  <= 1'b0;
         rdy_q   <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         edg_q   <= edg_d;
         retry_q <= retry_d;
         ena_q   <= ena_d;
         stby_q  <= stby_d;
         rdy_q   <= rdy_d;
         flt_q   <= flt_d;
      end
   end

   // Next state, counter updates, and outputs decoded from the next state.
   always_comb begin
      state_d = state_q;
      cyc_d   = sat_inc(cyc_q);
      edg_d   = edg_q;
      retry_d = retry_q;

      unique case (state_q)
         S_IDLE: begin
            cyc_d = '0;
            edg_d = '0;
            if (xo_req) begin
               state_d = S_BIAS;
            end
         end
         S_BIAS: begin
            if (cyc_q == BIAS_LIM) begin
               state_d = S_WAIT;
               cyc_d   = '0;
               edg_d   = '0;
            end
         end
         S_WAIT: begin
            if (dout_edge) begin
               edg_d = sat_inc(edg_q);
            end
            // Qualification beats timeout on the same cycle.
            if (dout_edge && edg_q == EDGE_LIM) begin
               state_d = S_RUN;
               cyc_d   = '0;
               edg_d   = '0;
               retry_d = '0;
            end else if (cyc_q == TMO_LIM) begin
               state_d = S_FAULT;
               cyc_d   = '0;
               edg_d   = '0;
            end
         end
         S_RUN: begin
            // cyc_q is the gap since the last edge.
            if (dout_edge) begin
               cyc_d = '0;
            end else if (cyc_q == LOSS_LIM) begin
               state_d = S_FAULT;
               cyc_d   = '0;
            end
         end
         S_FAULT: begin
            if (AUTORETRY &&
                cyc_q >= RTRY_LIM &&
                retry_q < RETRY_MAX) begin
               state_d = S_BIAS;
               cyc_d   = '0;
               retry_d = retry_q + RW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cyc_d   = '0;
            edg_d   = '0;
         end
      endcase

      // Dropping the request wins over anything above.
      if (!xo_req) begin
         state_d = S_IDLE;
         cyc_d   = '0;
         edg_d   = '0;
         retry_d = '0;
      end

      ena_d  = 1'b0;
      stby_d = 1'b0;
      rdy_d  = 1'b0;
      flt_d  = 1'b0;
      unique case (state_d)
         S_BIAS: begin
            ena_d  = 1'b1;
            stby_d = 1'b1;
         end
         S_WAIT: begin
            ena_d = 1'b1;
         end
         S_RUN: begin
            ena_d = 1'b1;
            rdy_d = 1'b1;
         end
         S_FAULT: begin
            flt_d = 1'b1;
         end
         default: begin
            ena_d = 1'b0;
         end
      endcase
   end

   assign xo_ena     = ena_q;
   assign xo_standby = stby_q;
   assign xo_ready   = rdy_q;
   assign xo_fault   = flt_q;
   assign xo_state   = state_q;

endmodule

// File: tb/tb_frigate_xo_startup_ctrl.sv
// tb_frigate_xo_startup_ctrl: vectors, directed corner sequences, random vs model.
// Honours FRIGATE_XO_AUTORETRY_EN the same way as the design.
module tb_frigate_xo_startup_ctrl;

   localparam int STARTUP_CYC  = 8;
   localparam int STABLE_EDGES = 4;
   localparam int TIMEOUT_CYC  = 100;
   localparam int LOSS_CYC     = 20;
   localparam int RETRY_CYC    = 10;
   localparam int MAX_RETRY    = 2;

`ifdef FRIGATE_XO_AUTORETRY_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   // {ena, standby, ready, fault, state}
   localparam logic [6:0] O_IDLE = 7'b0000_000;
   localparam logic [6:0] O_BIAS = 7'b1100_001;
   localparam logic [6:0] O_WAIT = 7'b1000_010;

   typedef struct packed {
      logic       r;
      logic       q;
      logic       d;
      logic [6:0] exp;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       xo_req;
   logic       xo_dout;
   logic       xo_ena;
   logic       xo_standby;
   logic       xo_ready;
   logic       xo_fault;
   logic [2:0] xo_state;
   logic [6:0] dut_out;

   int n_checks;
   int n_fail;

   // reference model: phase number, entry time, edge tally
   int m_ph;
   int m_tin;
   int m_edges;
   int m_last;
   int m_retry;
   int m_n;
   bit m_hist[$];

   frigate_xo_startup_ctrl #(
      .CNT_W       (16),
      .STARTUP_CYC (STARTUP_CYC),
      .STABLE_EDGES(STABLE_EDGES),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .LOSS_CYC    (LOSS_CYC),
      .RETRY_CYC   (RETRY_CYC),
      .MAX_RETRY   (MAX_RETRY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .xo_req    (xo_req),
      .xo_dout   (xo_dout),
      .xo_ena    (xo_ena),
      .xo_standby(xo_standby),
      .xo_ready  (xo_ready),
      .xo_fault  (xo_fault),
      .xo_state  (xo_state)
   );

   assign dut_out = {xo_ena, xo_standby, xo_ready,
                     xo_fault, xo_state};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mkv(bit r, bit q, bit d,
                                logic [6:0] e);
      vec_t v;
      v.r   = r;
      v.q   = q;
      v.d   = d;
      v.exp = e;
      return v;
   endfunction

   function automatic logic [6:0] model_out();
      logic [6:0] o;
      o[6]   = (m_ph >= 1 && m_ph <= 3);
      o[5]   = (m_ph == 1);
      o[4]   = (m_ph == 3);
      o[3]   = (m_ph == 4);
      o[2:0] = 3'(m_ph);
      return o;
   endfunction

   task automatic check_out(input string nm,
                            input logic [6:0] got,
                            input logic [6:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %b required %b (ena,stby,rdy,flt,state) t=%0t",
                  nm, got, exp, $time);
      end
   endtask

   task automatic check_int(input string nm,
                            input int got,
                            input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d t=%0t",
                  nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ph    = 0;
      m_tin   = 0;
      m_edges = 0;
      m_last  = -1;
      m_retry = 0;
      m_hist.delete();
      m_hist.push_back(1'b0);
      m_hist.push_back(1'b0);
      m_hist.push_back(1'b0);
   endtask

   // One controller clock: edge seen now is the rise of dout 2 clocks ago.
   task automatic model_step(input bit q, input bit d);
      bit e;
      int el;
      int nxt;
      int quiet_from;
      m_n++;
      e = m_hist[1] & ~m_hist[2];
      m_hist.push_front(d);
      void'(m_hist.pop_back());
      el  = m_n - m_tin + 1;
      nxt = m_ph;
      case (m_ph)
         0: if (q) nxt = 1;
         1: if (el == STARTUP_CYC) nxt = 2;
         2: begin
            if (e) m_edges++;
            if (m_edges == STABLE_EDGES) nxt = 3;
            else if (el == TIMEOUT_CYC) nxt = 4;
         end
         3: begin
            if (e) m_last = m_n;
            quiet_from = (m_last > m_tin - 1) ?
                         m_last : m_tin - 1;
            if (m_n - quiet_from == LOSS_CYC) nxt = 4;
         end
         4: begin
            if (AUTO && el >= RETRY_CYC &&
                m_retry < MAX_RETRY) begin
               nxt = 1;
               m_retry++;
            end
         end
         default: nxt = 0;
      endcase
      if (nxt == 3 && m_ph != 3) m_retry = 0;
      if (!q) begin
         nxt     = 0;
         m_retry = 0;
      end
      if (nxt != m_ph) begin
         m_tin   = m_n + 1;
         m_edges = 0;
         m_last  = -1;
      end
      m_ph = nxt;
   endtask

   task automatic edge_step(input bit r, input bit q,
                            input bit d);
      reset   = r;
      xo_req  = q;
      xo_dout = d;
      @(posedge clk);
      if (r) model_reset();
      else   model_step(q, d);
      #1;
   endtask

   task automatic tick(input bit r, input bit q,
                       input bit d);
      edge_step(r, q, d);
      check_out("cycle_vs_model", dut_out, model_out());
   endtask

   // Ticks with req=1, dout=0 while BIAS is observed; returns its length.
   task automatic bias_run(output int n);
      n = 0;
      tick(0, 1, 0);
      for (int c = 0; c < 40; c++) begin
         if (xo_state != 3'd1) break;
         n++;
         tick(0, 1, 0);
      end
   endtask

   initial begin
      vec_t       tbl[16];
      int         cnt;
      int         cnt2;
      int         k;
      int         k2;
      int         last_rise;
      int         flt_t;
      int         reent;
      int         nflt;
      int         half;
      int         len;
      int         dly;
      bit         seen;
      bit         rdy_seen;
      bit         prev_d;
      bit         d;
      bit         rq;
      bit         rs;
      bit         stuck;
      logic [2:0] prev_st;

      n_checks = 0;
      n_fail   = 0;
      m_n      = 0;
      reset    = 1'b1;
      xo_req   = 1'b0;
      xo_dout  = 1'b0;
      model_reset();

      tbl[0]  = mkv(1, 1, 1, O_IDLE);
      tbl[1]  = mkv(1, 1, 0, O_IDLE);
      tbl[2]  = mkv(1, 1, 1, O_IDLE);
      tbl[3]  = mkv(0, 0, 0, O_IDLE);
      tbl[4]  = mkv(0, 1, 0, O_BIAS);
      for (int i = 5; i < 12; i++) begin
         tbl[i] = mkv(0, 1, 0, O_BIAS);
      end
      tbl[12] = mkv(0, 1, 0, O_WAIT);
      tbl[13] = mkv(0, 1, 0, O_WAIT);
      tbl[14] = mkv(0, 0, 0, O_IDLE);
      tbl[15] = mkv(0, 1, 0, O_BIAS);

      for (int i = 0; i < 16; i++) begin
         edge_step(tbl[i].r, tbl[i].q, tbl[i].d);
         check_out($sformatf("table[%0d]", i),
                   dut_out, tbl[i].exp);
      end

      // startup with dout period 6
      tick(1, 1, 1);
      tick(1, 1, 0);
      cnt  = 0;
      seen = 0;
      k    = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         tick(0, 1, (k % 6) < 3);
         k++;
         if (xo_state == 3'd1) cnt++;
         if (xo_ready) seen = 1;
      end
      check_int("bias_len", cnt, STARTUP_CYC);
      check_int("ready_reached", int'(seen), 1);

      // edges every 19 clocks keep RUN alive
      cnt    = 0;
      cnt2   = 0;
      k2     = 9;
      prev_d = 0;
      last_rise = m_n;
      for (int c = 0; c < 200; c++) begin
         d = (k2 % 19) < 9;
         k2++;
         tick(0, 1, d);
         if (d && !prev_d) last_rise = m_n;
         prev_d = d;
         if (xo_fault) cnt++;
         if (!xo_ready) cnt2++;
      end
      check_int("no_fault_period19", cnt, 0);
      check_int("ready_held_period19", cnt2, 0);

      // stop dout: loss of clock
      seen = 0;
      dly  = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
         tick(0, 1, 0);
         if (xo_fault) begin
            seen = 1;
            dly  = m_n - last_rise;
         end
      end
      check_int("loss_detected", int'(seen), 1);
      check_int("loss_delay_window",
                int'(dly >= LOSS_CYC && dly <= LOSS_CYC + 3), 1);
      check_int("ready_dropped", int'(xo_ready), 0);

      // dout stuck: timeout after standby release
      tick(1, 1, 0);
      tick(1, 1, 0);
      cnt      = 0;
      seen     = 0;
      rdy_seen = 0;
      for (int c = 0; c < 300 && !seen; c++) begin
         tick(0, 1, 0);
         if (xo_ready) rdy_seen = 1;
         if (xo_fault) seen = 1;
         else if (xo_state == 3'd2) cnt++;
      end
      check_int("timeout_fault", int'(seen), 1);
      check_int("timeout_len", cnt, TIMEOUT_CYC);
      check_int("timeout_never_ready", int'(rdy_seen), 0);
      check_int("timeout_ena_low", int'(xo_ena), 0);

      // retry behaviour with dout stuck
      tick(1, 1, 0);
      tick(1, 1, 0);
      prev_st = 3'd0;
      reent   = 0;
      nflt    = 0;
      flt_t   = 0;
      for (int c = 0; c < 500; c++) begin
         tick(0, 1, 0);
         if (xo_state != prev_st) begin
            if (xo_state == 3'd4) begin
               nflt++;
               flt_t = m_n;
            end
            if (prev_st == 3'd4 && xo_state == 3'd1) begin
               reent++;
               check_int("retry_delay", m_n - flt_t,
                         RETRY_CYC);
            end
         end
         prev_st = xo_state;
      end
      check_int("retry_reentries", reent, AUTO ? 2 : 0);
      check_int("fault_entries", nflt, AUTO ? 3 : 1);
      check_int("fault_sticky", int'(xo_fault), 1);

      // req drop mid-BIAS, mid-WAIT and on the fault cycle
      tick(1, 1, 0);
      tick(1, 1, 0);
      tick(0, 1, 0);
      tick(0, 1, 0);
      tick(0, 1, 0);
      tick(0, 0, 0);
      check_out("drop_in_bias", dut_out, O_IDLE);
      bias_run(cnt);
      check_int("bias_len_after_drop1", cnt, STARTUP_CYC);
      for (int c = 0; c < 10; c++) tick(0, 1, 0);
      tick(0, 0, 0);
      check_out("drop_in_wait", dut_out, O_IDLE);
      bias_run(cnt);
      check_int("bias_len_after_drop2", cnt, STARTUP_CYC);
      cnt = (xo_state == 3'd2) ? 1 : 0;
      for (int c = 0; c < 200 && cnt < TIMEOUT_CYC; c++) begin
         tick(0, 1, 0);
         if (xo_state == 3'd2) cnt++;
      end
      check_int("wait_before_fault", cnt, TIMEOUT_CYC);
      tick(0, 0, 0);
      check_out("drop_on_fault_cycle", dut_out, O_IDLE);
      bias_run(cnt);
      check_int("bias_len_after_drop3", cnt, STARTUP_CYC);

      // random stimulus against the model
      tick(1, 0, 0);
      k = 0;
      for (int ep = 0; ep < 25; ep++) begin
         half  = $urandom_range(2, 11);
         len   = $urandom_range(60, 260);
         stuck = ($urandom_range(0, 4) == 0);
         rq    = 1;
         for (int c = 0; c < len; c++) begin
            if (rq && $urandom_range(0, 99) == 0) rq = 0;
            else if (!rq && $urandom_range(0, 3) == 0) rq = 1;
            rs = ($urandom_range(0, 999) == 0);
            d  = stuck ? 1'b0 : ((k % (2 * half)) < half);
            k++;
            tick(rs, rq, d);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
